// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: issues sequential reads to a synchronous instruction memory,
// buffers returned words in a small prefetch FIFO and presents {instr, pc} to decode.

module fetch_prefetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          CLK,
  input logic          RST,
  input logic          push,
  input logic          pop,
  input logic          occEmpty,
  input logic          occFull,
  input logic [CW-1:0] count
);
  popFromEmpty: assert property (@(posedge CLK) disable iff (RST)
    !(pop && (count == CW'(0))));

  pushToFull: assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && (count == CW'(DEPTH))));

  occTracksCount: assert property (@(posedge CLK) disable iff (RST)
    (occEmpty == (count == CW'(0))) && (occFull == (count == CW'(DEPTH))));
endmodule

module fetch_prefetch_queue #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic [ADDR_W-1:0]      imem_addr,
  output logic                   imem_rd,
  input  logic [DATA_W-1:0]      imem_data,
  output logic [DATA_W-1:0]      dec_instr,
  output logic [ADDR_W-1:0]      dec_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  input  logic                   fetch_hold,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occState_t;

  logic [ADDR_W-1:0] fetchPcR;
  logic [ADDR_W-1:0] inflightPcR;
  logic              inflightR;
  logic [PW-1:0]     headR;
  logic [PW-1:0]     tailR;
  logic [CW-1:0]     countR;
  logic [CW-1:0]     countNextS;
  logic [DATA_W-1:0] instrQ [DEPTH];
  logic [ADDR_W-1:0] pcQ [DEPTH];
  logic              pushS;
  logic              popS;
  logic              issueS;
  logic [SW-1:0]     demandS;
  logic [SW-1:0]     limitS;
  occState_t         occStateR;
  occState_t         occNextS;
  logic              occEmptyS;
  logic              occFullS;

  // Redirect overrides everything: no pop, no push of the returning word, no issue.
  assign dec_valid  = (countR != CW'(0));
  assign popS       = dec_valid & dec_ready & ~redirect;
  assign pushS      = inflightR & ~redirect;
  assign countNextS = countR + CW'(pushS) - CW'(popS);

  // An in-flight read already owns a queue slot, so only issue when one is still free.
  assign demandS = SW'(countR) + SW'(inflightR);
  assign limitS  = SW'(DEPTH) + SW'(popS);
  assign issueS  = ~RST & ~redirect & ~fetch_hold & (demandS < limitS);

  assign imem_rd   = issueS;
  assign imem_addr = fetchPcR;
  assign q_count   = countR;
  assign dec_instr = dec_valid ? instrQ[headR] : {DATA_W{1'b0}};
  assign dec_pc    = dec_valid ? pcQ[headR] : {ADDR_W{1'b0}};

  // Fetch PC and single outstanding read tracking
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetchPcR    <= {ADDR_W{1'b0}};
      inflightR   <= 1'b0;
      inflightPcR <= {ADDR_W{1'b0}};
    end else if (redirect) begin
      fetchPcR  <= redirect_pc;
      inflightR <= 1'b0;
    end else begin
      inflightR <= issueS;
      if (issueS) begin
        inflightPcR <= fetchPcR;
        fetchPcR    <= fetchPcR + ADDR_W'(1);
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      headR  <= {PW{1'b0}};
      tailR  <= {PW{1'b0}};
      countR <= {CW{1'b0}};
    end else if (redirect) begin
      headR  <= {PW{1'b0}};
      tailR  <= {PW{1'b0}};
      countR <= {CW{1'b0}};
    end else begin
      if (pushS) begin
        tailR <= tailR + PW'(1);
      end
      if (popS) begin
        headR <= headR + PW'(1);
      end
      countR <= countNextS;
    end
  end

  // Queue storage; contents are only observed through valid slots
  always_ff @(posedge CLK) begin
    if (pushS) begin
      instrQ[tailR] <= imem_data;
      pcQ[tailR]    <= inflightPcR;
    end
  end

  // Occupancy state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occStateR <= OCC_EMPTY;
    end else begin
      occStateR <= occNextS;
    end
  end

  // Occupancy next state, following the count held after this edge
  always_comb begin
    occNextS = occStateR;
    if (redirect) begin
      occNextS = OCC_EMPTY;
    end else begin
      case (occStateR)
        OCC_EMPTY: begin
          if (pushS) begin
            occNextS = OCC_PARTIAL;
          end else begin
            occNextS = OCC_EMPTY;
          end
        end
        OCC_PARTIAL: begin
          if (countNextS == CW'(DEPTH)) begin
            occNextS = OCC_FULL;
          end else if (countNextS == CW'(0)) begin
            occNextS = OCC_EMPTY;
          end else begin
            occNextS = OCC_PARTIAL;
          end
        end
        OCC_FULL: begin
          if (countNextS != CW'(DEPTH)) begin
            occNextS = OCC_PARTIAL;
          end else begin
            occNextS = OCC_FULL;
          end
        end
        default: occNextS = OCC_EMPTY;
      endcase
    end
  end

  assign occEmptyS = (occStateR == OCC_EMPTY);
  assign occFullS  = (occStateR == OCC_FULL);

  fetch_prefetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) chk (
    .CLK      (CLK),
    .RST      (RST),
    .push     (pushS),
    .pop      (popS),
    .occEmpty (occEmptyS),
    .occFull  (occFullS),
    .count    (countR)
  );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus a randomized run checked
// against a queue-level reference model of the fetch stage.
module tb_fetch_prefetch_queue;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] dec_instr;
  logic [11:0] dec_pc;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic        fetch_hold = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;
  logic [2:0]  q_count;

  int errCount = 0;
  int checkCount = 0;
  logic [15:0] memArr [4096];

  fetch_prefetch_queue #(.ADDR_W(12), .DATA_W(16), .DEPTH(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .fetch_hold  (fetch_hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .q_count     (q_count)
  );

  always #5 CLK = ~CLK;

  // synchronous instruction memory: data the cycle after the read
  always @(posedge CLK) begin
    if (imem_rd) imem_data <= memArr[imem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic apply_reset();
    RST = 1'b1; dec_ready = 1'b0; fetch_hold = 1'b0; redirect = 1'b0; redirect_pc = 12'h000;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    dec_ready = 1'b1;
    @(negedge CLK);
    checkCount++;
    if ({imem_rd, imem_addr} !== 13'h0) begin
      errCount++; $display("FAIL reset_fetch: rd/addr=%0b/%0h expected 0/0", imem_rd, imem_addr);
    end
    checkCount++;
    if ({dec_valid, dec_pc, dec_instr, q_count} !== 32'h0) begin
      errCount++;
      $display("FAIL reset_decode: valid=%0b pc=%0h instr=%0h cnt=%0d expected all 0",
               dec_valid, dec_pc, dec_instr, q_count);
    end
  endtask

  task automatic test_stream();
    logic [11:0] expPc;
    apply_reset();
    dec_ready = 1'b1;
    @(negedge CLK);
    checkCount++;
    if ({imem_rd, imem_addr, dec_valid} !== {1'b1, 12'h000, 1'b0}) begin
      errCount++; $display("FAIL stream_first_issue: rd=%0b addr=%0h valid=%0b expected 1/0/0", imem_rd, imem_addr, dec_valid);
    end
    @(posedge CLK); #1; @(negedge CLK);
    checkCount++;
    if ({imem_rd, imem_addr, dec_valid} !== {1'b1, 12'h001, 1'b0}) begin
      errCount++; $display("FAIL stream_second_issue: rd=%0b addr=%0h valid=%0b expected 1/1/0", imem_rd, imem_addr, dec_valid);
    end
    expPc = 12'h000;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1; @(negedge CLK);
      checkCount++;
      if ({dec_valid, dec_pc, dec_instr} !== {1'b1, expPc, 16'hA000 + {4'h0, expPc}}) begin
        errCount++;
        $display("FAIL stream_word: valid=%0b pc=%0h instr=%0h expected 1/%0h/%0h",
                 dec_valid, dec_pc, dec_instr, expPc, 16'hA000 + {4'h0, expPc});
      end
      expPc = expPc + 12'd1;
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] expPc;
    int got;
    apply_reset();
    repeat (10) begin @(posedge CLK); #1; end
    @(negedge CLK);
    checkCount++;
    if ({q_count, imem_rd, dec_valid, dec_pc} !== {3'd4, 1'b0, 1'b1, 12'h000}) begin
      errCount++;
      $display("FAIL bp_saturate: cnt=%0d rd=%0b valid=%0b pc=%0h expected 4/0/1/0", q_count, imem_rd, dec_valid, dec_pc);
    end
    @(posedge CLK); #1 dec_ready = 1'b1;
    @(negedge CLK);
    checkCount++;
    if ({imem_rd, imem_addr} !== {1'b1, 12'h004}) begin
      errCount++; $display("FAIL bp_resume_issue: rd=%0b addr=%0h expected 1/4", imem_rd, imem_addr);
    end
    expPc = 12'h000; got = 0;
    for (int c = 0; c < 40 && got < 12; c++) begin
      if (dec_valid) begin
        checkCount++;
        if ({dec_pc, dec_instr} !== {expPc, 16'hA000 + {4'h0, expPc}}) begin
          errCount++; $display("FAIL bp_order: pc=%0h instr=%0h expected %0h/%0h", dec_pc, dec_instr, expPc, 16'hA000 + {4'h0, expPc});
        end
        expPc = expPc + 12'd1; got++;
      end
      @(posedge CLK); #1; @(negedge CLK);
    end
    checkCount++;
    if (got != 12) begin errCount++; $display("FAIL bp_drain_count: got %0d words expected 12", got); end
  endtask

  task automatic test_redirect();
    apply_reset();
    repeat (4) begin @(posedge CLK); #1; end
    redirect = 1'b1; redirect_pc = 12'h080;
    @(negedge CLK);
    checkCount++;
    if ({q_count, imem_rd} !== {3'd3, 1'b0}) begin
      errCount++; $display("FAIL redir_setup: cnt=%0d rd=%0b expected 3/0", q_count, imem_rd);
    end
    @(posedge CLK); #1 redirect = 1'b0; dec_ready = 1'b1;
    @(negedge CLK);
    checkCount++;
    if ({q_count, dec_valid, imem_rd, imem_addr} !== {3'd0, 1'b0, 1'b1, 12'h080}) begin
      errCount++;
      $display("FAIL redir_t1: cnt=%0d valid=%0b rd=%0b addr=%0h expected 0/0/1/80", q_count, dec_valid, imem_rd, imem_addr);
    end
    @(posedge CLK); #1; @(negedge CLK);
    checkCount++;
    if (dec_valid !== 1'b0) begin errCount++; $display("FAIL redir_t2_valid: got %0b expected 0", dec_valid); end
    @(posedge CLK); #1; @(negedge CLK);
    checkCount++;
    if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 12'h080, 16'hA080}) begin
      errCount++; $display("FAIL redir_t3_word: valid=%0b pc=%0h instr=%0h expected 1/80/a080", dec_valid, dec_pc, dec_instr);
    end
    @(posedge CLK); #1; @(negedge CLK);
    checkCount++;
    if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 12'h081, 16'hA081}) begin
      errCount++; $display("FAIL redir_t4_word: valid=%0b pc=%0h instr=%0h expected 1/81/a081", dec_valid, dec_pc, dec_instr);
    end
  endtask

  task automatic test_hold();
    logic [11:0] expPc;
    int got;
    apply_reset();
    @(negedge CLK);
    checkCount++;
    if ({imem_rd, imem_addr} !== {1'b1, 12'h000}) begin
      errCount++; $display("FAIL hold_first_issue: rd=%0b addr=%0h expected 1/0", imem_rd, imem_addr);
    end
    @(posedge CLK); #1 fetch_hold = 1'b1;
    @(negedge CLK);
    checkCount++;
    if (imem_rd !== 1'b0) begin errCount++; $display("FAIL hold_block: rd=%0b expected 0", imem_rd); end
    repeat (3) begin
      @(posedge CLK); #1; @(negedge CLK);
      checkCount++;
      if ({imem_rd, q_count, dec_valid, dec_pc} !== {1'b0, 3'd1, 1'b1, 12'h000}) begin
        errCount++;
        $display("FAIL hold_inflight_kept: rd=%0b cnt=%0d valid=%0b pc=%0h expected 0/1/1/0", imem_rd, q_count, dec_valid, dec_pc);
      end
    end
    @(posedge CLK); #1 fetch_hold = 1'b0;
    @(negedge CLK);
    checkCount++;
    if ({imem_rd, imem_addr} !== {1'b1, 12'h001}) begin
      errCount++; $display("FAIL hold_resume: rd=%0b addr=%0h expected 1/1", imem_rd, imem_addr);
    end
    @(posedge CLK); #1 dec_ready = 1'b1;
    @(negedge CLK);
    expPc = 12'h000; got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (dec_valid) begin
        checkCount++;
        if ({dec_pc, dec_instr} !== {expPc, 16'hA000 + {4'h0, expPc}}) begin
          errCount++; $display("FAIL hold_order: pc=%0h instr=%0h expected %0h/%0h", dec_pc, dec_instr, expPc, 16'hA000 + {4'h0, expPc});
        end
        expPc = expPc + 12'd1; got++;
      end
      @(posedge CLK); #1; @(negedge CLK);
    end
    checkCount++;
    if (got != 4) begin errCount++; $display("FAIL hold_drain_count: got %0d words expected 4", got); end
  endtask

  task automatic test_wrap();
    logic [11:0] expPc;
    int got;
    apply_reset();
    dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'hFFE;
    @(negedge CLK);
    checkCount++;
    if (imem_rd !== 1'b0) begin errCount++; $display("FAIL wrap_redirect_rd: rd=%0b expected 0", imem_rd); end
    @(posedge CLK); #1 redirect = 1'b0;
    @(negedge CLK);
    expPc = 12'hFFE; got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (dec_valid) begin
        checkCount++;
        if ({dec_pc, dec_instr} !== {expPc, 16'hA000 + {4'h0, expPc}}) begin
          errCount++; $display("FAIL wrap_order: pc=%0h instr=%0h expected %0h/%0h", dec_pc, dec_instr, expPc, 16'hA000 + {4'h0, expPc});
        end
        expPc = expPc + 12'd1; got++;
      end
      @(posedge CLK); #1; @(negedge CLK);
    end
    checkCount++;
    if (got != 4) begin errCount++; $display("FAIL wrap_count: got %0d words expected 4", got); end
  endtask

  task automatic test_async_reset();
    int got;
    apply_reset();
    repeat (8) begin @(posedge CLK); #1; end
    @(negedge CLK);
    checkCount++;
    if (q_count !== 3'd4) begin errCount++; $display("FAIL areset_full: cnt=%0d expected 4", q_count); end
    @(posedge CLK); #3 RST = 1'b1;
    #1;
    checkCount++;
    if ({imem_rd, imem_addr, dec_valid, dec_pc, dec_instr, q_count} !== 45'h0) begin
      errCount++;
      $display("FAIL areset_clear: rd=%0b addr=%0h valid=%0b pc=%0h instr=%0h cnt=%0d expected all 0",
               imem_rd, imem_addr, dec_valid, dec_pc, dec_instr, q_count);
    end
    @(posedge CLK); #1 RST = 1'b0; dec_ready = 1'b1;
    @(negedge CLK);
    checkCount++;
    if ({imem_rd, imem_addr} !== {1'b1, 12'h000}) begin
      errCount++; $display("FAIL areset_restart: rd=%0b addr=%0h expected 1/0", imem_rd, imem_addr);
    end
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      if (dec_valid) begin
        checkCount++;
        if ({dec_pc, dec_instr} !== {12'h000, 16'hA000}) begin
          errCount++; $display("FAIL areset_first_word: pc=%0h instr=%0h expected 0/a000", dec_pc, dec_instr);
        end
        got++;
      end
      @(posedge CLK); #1; @(negedge CLK);
    end
    checkCount++;
    if (got != 1) begin errCount++; $display("FAIL areset_timeout: no word seen after restart"); end
  endtask

  task automatic test_random();
    logic [11:0] mq[$];
    logic        mInfl;
    logic [11:0] mInflPc;
    logic [11:0] mFetchPc;
    logic        mPop;
    logic        expRd;
    for (int i = 0; i < 4096; i++) memArr[i] = 16'($urandom);
    apply_reset();
    mInfl = 1'b0; mInflPc = 12'h000; mFetchPc = 12'h000;
    for (int c = 0; c < 600; c++) begin
      dec_ready   = ($urandom_range(0, 99) < 65);
      fetch_hold  = ($urandom_range(0, 99) < 20);
      redirect    = ($urandom_range(0, 99) < 6);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3)) : 12'($urandom);
      @(negedge CLK);
      mPop  = (mq.size() > 0) && dec_ready && !redirect;
      expRd = !redirect && !fetch_hold && ((mq.size() + int'(mInfl)) < (4 + int'(mPop)));
      checkCount++;
      if ({dec_valid, q_count} !== {(mq.size() > 0), 3'(mq.size())}) begin
        errCount++; $display("FAIL rnd_occupancy: valid=%0b cnt=%0d expected %0b/%0d", dec_valid, q_count, mq.size() > 0, mq.size());
      end
      if (mq.size() > 0) begin
        checkCount++;
        if ({dec_pc, dec_instr} !== {mq[0], memArr[mq[0]]}) begin
          errCount++; $display("FAIL rnd_head: pc=%0h instr=%0h expected %0h/%0h", dec_pc, dec_instr, mq[0], memArr[mq[0]]);
        end
      end
      checkCount++;
      if (imem_rd !== expRd) begin errCount++; $display("FAIL rnd_issue: rd=%0b expected %0b", imem_rd, expRd); end
      if (expRd) begin
        checkCount++;
        if (imem_addr !== mFetchPc) begin errCount++; $display("FAIL rnd_addr: addr=%0h expected %0h", imem_addr, mFetchPc); end
      end
      if (redirect) begin
        mq.delete(); mInfl = 1'b0; mFetchPc = redirect_pc;
      end else begin
        if (mPop) void'(mq.pop_front());
        if (mInfl) mq.push_back(mInflPc);
        mInfl = expRd;
        if (expRd) begin mInflPc = mFetchPc; mFetchPc = mFetchPc + 12'd1; end
      end
      @(posedge CLK); #1;
    end
    redirect = 1'b0; fetch_hold = 1'b0; dec_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) memArr[i] = 16'hA000 + 16'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
